axi_wr_data_sync_fifo: RTL and testbench

//  Single-clock FIFO for the AXI4 W channel (wdata+wstrb+wlast), successor to the fixed 37-bit async write-data FIFO.

---
 rtl/axi_fifo_pkg.sv | 15 +
 rtl/axi_fifo_sdpram.sv | 33 +++
 rtl/axi_wr_data_sync_fifo.sv | 122 ++++++++++++
 tb/tb_axi_wr_data_sync_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_fifo_pkg.sv
// Shared definitions for the AXI W-channel FIFO: entry width helper, entry
// packing order and output-stage state encodings.
package axi_fifo_pkg;

  // Entries are packed {last, strb, data}, last in the MSB.
  function automatic int AXI_W_ENTRY_W(input int dw);
    return dw + dw / 8 + 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } ostate_e;

endpackage

// File: rtl/axi_fifo_sdpram.sv
// Simple dual-port RAM: one write port, one synchronous read port with read
// enable. The array itself is never reset; only the read register is.
module axi_fifo_sdpram #(
  parameter int W  = 37,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // The read register doubles as the FIFO output register, so it only
  // advances on a read issue and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_wr_data_sync_fifo.sv
// Single-clock AXI4 W-channel FIFO with FWFT output register, threshold flags,
// burst counting and optional store-and-forward (packet) release.
module axi_wr_data_sync_fifo
  import axi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH_WIDTH      = 9,
  parameter int ALMOST_FULL_NUM  = 60,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int PACKET_MODE      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [DEPTH_WIDTH:0]    water_level,
  output logic [DEPTH_WIDTH:0]    burst_count
);

  localparam int ENTRY_W = AXI_W_ENTRY_W(DATA_WIDTH);
  localparam int PW      = DEPTH_WIDTH + 1;
  localparam logic [PW:0]   CAPACITY = (PW+1)'(2**DEPTH_WIDTH);
  localparam logic [PW-1:0] AF_LEVEL = PW'(2**DEPTH_WIDTH - ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_LEVEL = PW'(ALMOST_EMPTY_NUM);

  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_cmt_ptr, r_burst_cnt;
  ostate_e       r_state;
  logic          r_s_wready, r_almost_full, r_almost_empty;

  logic               w_wr_en, w_avail, w_rd_issue, w_m_hs, w_mvalid_nxt;
  logic               w_wr_last, w_rd_last;
  logic [PW-1:0]      w_wr_ptr_nxt, w_rd_ptr_nxt, w_level_nxt, w_burst_nxt;
  logic [PW:0]        w_occ_nxt;
  logic [ENTRY_W-1:0] w_wr_entry, w_rd_entry;

  assign w_wr_en    = s_wvalid && r_s_wready;
  assign w_avail    = (PACKET_MODE != 0) ? (r_rd_ptr != r_cmt_ptr) : (r_rd_ptr != r_wr_ptr);
  assign w_m_hs     = m_wvalid && m_wready;
  assign w_rd_issue = w_avail && (!m_wvalid || m_wready);
  assign w_wr_last  = w_wr_en && s_wlast;
  assign w_rd_last  = w_m_hs && m_wlast;

  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_en);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_issue);
  assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
  assign w_mvalid_nxt = w_rd_issue || (m_wvalid && !m_wready);
  // Capacity includes the output register, so the beat held there counts.
  assign w_occ_nxt    = {1'b0, w_level_nxt} + (PW+1)'(w_mvalid_nxt);

  always_comb begin
    w_burst_nxt = r_burst_cnt;
    if (w_wr_last && !w_rd_last)      w_burst_nxt = r_burst_cnt + PW'(1);
    else if (!w_wr_last && w_rd_last) w_burst_nxt = r_burst_cnt - PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_cmt_ptr      <= '0;
      r_burst_cnt    <= '0;
      r_s_wready     <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      if (w_wr_last) r_cmt_ptr <= w_wr_ptr_nxt;
      r_burst_cnt    <= w_burst_nxt;
      r_s_wready     <= (w_occ_nxt < CAPACITY);
      r_almost_full  <= (w_level_nxt >= AF_LEVEL);
      r_almost_empty <= (w_level_nxt <= AE_LEVEL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_rd_issue) r_state <= VALID;
        VALID:   if (w_m_hs && !w_avail) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_wr_entry = {s_wlast, s_wstrb, s_wdata};

  axi_fifo_sdpram #(
    .W  (ENTRY_W),
    .AW (DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[DEPTH_WIDTH-1:0]),
    .i_wdata (w_wr_entry),
    .i_re    (w_rd_issue),
    .i_raddr (r_rd_ptr[DEPTH_WIDTH-1:0]),
    .o_rdata (w_rd_entry)
  );

  assign {m_wlast, m_wstrb, m_wdata} = w_rd_entry;
  assign m_wvalid     = (r_state == VALID);
  assign s_wready     = r_s_wready;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign water_level  = r_wr_ptr - r_rd_ptr;
  assign burst_count  = r_burst_cnt;

endmodule

// File: tb/tb_axi_wr_data_sync_fifo.sv
// Bench for axi_wr_data_sync_fifo: a cut-through instance (DW=32, 512 deep) and a
// small packet-mode instance, each with an in-order scoreboard on its output side.
module tb_axi_wr_data_sync_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] c_wdata, c_mdata;
  logic [3:0]  c_wstrb, c_mstrb;
  logic        c_wlast, c_wvalid, c_swready, c_mlast, c_mvalid, c_mready, c_af, c_ae;
  logic [9:0]  c_lvl, c_bc;

  logic [31:0] p_wdata, p_mdata;
  logic [3:0]  p_wstrb, p_mstrb;
  logic        p_wlast, p_wvalid, p_swready, p_mlast, p_mvalid, p_mready, p_af, p_ae;
  logic [4:0]  p_lvl, p_bc;

  axi_wr_data_sync_fifo #(
    .DATA_WIDTH(32), .DEPTH_WIDTH(9), .ALMOST_FULL_NUM(60), .ALMOST_EMPTY_NUM(4), .PACKET_MODE(0)
  ) dut_ct (
    .clk(clk), .rst(rst),
    .s_wdata(c_wdata), .s_wstrb(c_wstrb), .s_wlast(c_wlast), .s_wvalid(c_wvalid), .s_wready(c_swready),
    .m_wdata(c_mdata), .m_wstrb(c_mstrb), .m_wlast(c_mlast), .m_wvalid(c_mvalid), .m_wready(c_mready),
    .almost_full(c_af), .almost_empty(c_ae), .water_level(c_lvl), .burst_count(c_bc)
  );

  axi_wr_data_sync_fifo #(
    .DATA_WIDTH(32), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(2), .PACKET_MODE(1)
  ) dut_pk (
    .clk(clk), .rst(rst),
    .s_wdata(p_wdata), .s_wstrb(p_wstrb), .s_wlast(p_wlast), .s_wvalid(p_wvalid), .s_wready(p_swready),
    .m_wdata(p_mdata), .m_wstrb(p_mstrb), .m_wlast(p_mlast), .m_wvalid(p_mvalid), .m_wready(p_mready),
    .almost_full(p_af), .almost_empty(p_ae), .water_level(p_lvl), .burst_count(p_bc)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit abort    = 1'b0;

  logic [36:0] c_exp[$];
  logic [36:0] p_exp[$];
  logic        c_stall, p_stall;
  logic [36:0] c_held, p_held;
  int          p_blen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats are pushed as they are accepted and popped on output handshakes.
  always @(negedge clk) begin
    if (rst) begin
      c_exp.delete();
      c_stall <= 1'b0;
    end else begin
      if (c_wvalid && c_swready) c_exp.push_back({c_wlast, c_wstrb, c_wdata});
      if (c_stall) begin
        chk("ct_hold_valid", c_mvalid, 1);
        chk("ct_hold_beat", {c_mlast, c_mstrb, c_mdata}, c_held);
      end
      if (c_mvalid && c_mready) begin
        n_checks++;
        if (c_exp.size() == 0) begin
          n_errors++;
          $display("FAIL ct_unexpected_beat: got 0x%0h, expected no beat", {c_mlast, c_mstrb, c_mdata});
        end else begin
          n_checks--;
          chk("ct_beat", {c_mlast, c_mstrb, c_mdata}, c_exp.pop_front());
        end
      end
      c_stall <= c_mvalid && !c_mready;
      c_held  <= {c_mlast, c_mstrb, c_mdata};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      p_exp.delete();
      p_stall <= 1'b0;
      p_blen  = 0;
    end else begin
      if (p_wvalid && p_swready) begin
        p_exp.push_back({p_wlast, p_wstrb, p_wdata});
        p_blen++;
        assert (p_blen <= 16) else begin
          n_errors++;
          $display("FAIL pk_burst_len: got %0d beats, limit 16", p_blen);
        end
        if (p_wlast) p_blen = 0;
      end
      if (p_stall) chk("pk_hold_beat", {p_mvalid, p_mlast, p_mstrb, p_mdata}, {1'b1, p_held});
      if (p_mvalid && p_mready) begin
        n_checks++;
        if (p_exp.size() == 0) begin
          n_errors++;
          $display("FAIL pk_unexpected_beat: got 0x%0h, expected no beat", {p_mlast, p_mstrb, p_mdata});
        end else begin
          n_checks--;
          chk("pk_beat", {p_mlast, p_mstrb, p_mdata}, p_exp.pop_front());
        end
      end
      p_stall <= p_mvalid && !p_mready;
      p_held  <= {p_mlast, p_mstrb, p_mdata};
    end
  end

  task automatic ct_beat(input logic [31:0] d, input logic [3:0] s, input logic l, input bit rnd);
    int  waitc;
    bit  acc;
    if (abort) return;
    c_wdata  = d;
    c_wstrb  = s;
    c_wlast  = l;
    c_wvalid = !rnd;
    waitc    = 0;
    do begin
      if (rnd) begin
        if (!c_wvalid) c_wvalid = ($urandom_range(0, 1) == 1);
        c_mready = ($urandom_range(0, 1) == 1);
      end
      acc = c_wvalid && c_swready;
      tick();
      waitc++;
    end while (!acc && waitc < 64);
    c_wvalid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_errors++;
      abort = 1'b1;
      $display("FAIL ct_wr_timeout: got no acceptance in %0d cycles, expected s_wready", waitc);
    end
  endtask

  task automatic drain_ct();
    int n = 0;
    c_mready = 1'b1;
    while ((c_exp.size() != 0 || c_mvalid) && n < 4000) begin
      tick();
      n++;
    end
    chk("ct_drain_done", (n < 4000), 1);
  endtask

  initial begin
    rst = 1'b1;
    c_wdata = '0; c_wstrb = '0; c_wlast = 1'b0; c_wvalid = 1'b0; c_mready = 1'b0;
    p_wdata = '0; p_wstrb = '0; p_wlast = 1'b0; p_wvalid = 1'b0; p_mready = 1'b0;
    repeat (3) tick();
    chk("rst_s_wready", c_swready, 0);
    chk("rst_m_wvalid", c_mvalid, 0);
    rst = 1'b0;
    tick();

    // Idle after reset release
    chk("idle_s_wready", c_swready, 1);
    chk("idle_m_wvalid", c_mvalid, 0);
    chk("idle_level", c_lvl, 0);
    chk("idle_almost_empty", c_ae, 1);
    chk("idle_almost_full", c_af, 0);
    chk("idle_burst_count", c_bc, 0);

    // Single-beat cut-through latency
    c_wdata = 32'hA5A5_A5A5; c_wstrb = 4'hF; c_wlast = 1'b1; c_wvalid = 1'b1;
    tick();
    c_wvalid = 1'b0;
    chk("ct_lat_edgeN_valid", c_mvalid, 0);
    chk("ct_lat_edgeN_level", c_lvl, 1);
    chk("ct_lat_edgeN_bursts", c_bc, 1);
    tick();
    chk("ct_lat_edgeN1_valid", c_mvalid, 1);
    chk("ct_lat_edgeN1_data", c_mdata, 32'hA5A5_A5A5);
    chk("ct_lat_edgeN1_level", c_lvl, 0);
    c_mready = 1'b1;
    tick();
    c_mready = 1'b0;
    chk("ct_after_read_valid", c_mvalid, 0);
    chk("ct_after_read_bursts", c_bc, 0);

    // Fill to capacity with the consumer stalled, then drain
    for (int i = 0; i < 512; i++) begin
      ct_beat(32'h3000_0000 + 32'(i), 4'(i), (i % 16) == 15, 1'b0);
      if (i == 451) begin
        chk("fill_level_451", c_lvl, 451);
        chk("fill_af_below", c_af, 0);
      end
      if (i == 452) begin
        chk("fill_level_452", c_lvl, 452);
        chk("fill_af_at", c_af, 1);
      end
      if (i == 510) chk("fill_ready_511", c_swready, 1);
    end
    chk("full_s_wready", c_swready, 0);
    chk("full_level", c_lvl, 511);
    chk("full_bursts", c_bc, 32);
    chk("full_out_reg", {c_mvalid, c_mdata}, {1'b1, 32'h3000_0000});
    chk("full_almost_empty", c_ae, 0);
    c_wdata = 32'hDEAD_BEEF; c_wvalid = 1'b1;
    repeat (3) tick();
    c_wvalid = 1'b0;
    chk("full_no_overwrite_level", c_lvl, 511);
    drain_ct();
    chk("drain_level", c_lvl, 0);
    chk("drain_bursts", c_bc, 0);
    chk("drain_almost_empty", c_ae, 1);
    chk("drain_s_wready", c_swready, 1);

    // Packet mode: nothing leaves until the wlast beat is stored
    p_mready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p_wdata = 32'hB000_0000 + 32'(i); p_wstrb = 4'(i + 1); p_wlast = (i == 7); p_wvalid = 1'b1;
      tick();
      chk($sformatf("pk_hold_off_beat%0d", i + 1), p_mvalid, 0);
    end
    p_wvalid = 1'b0;
    chk("pk_level_8", p_lvl, 8);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("pk_contig_%0d", j), p_mvalid, 1);
    end
    tick();
    chk("pk_burst_end", p_mvalid, 0);
    chk("pk_level_0", p_lvl, 0);
    chk("pk_bursts_0", p_bc, 0);
    chk("pk_flags", {p_ae, p_af}, 2'b10);
    chk("pk_sb_empty", p_exp.size(), 0);

    // Random traffic on both sides, random burst lengths
    begin
      int total = 0;
      while (total < 10000 && !abort) begin
        int len = $urandom_range(1, 256);
        for (int b = 0; b < len; b++) ct_beat($urandom, 4'($urandom), b == len - 1, 1'b1);
        total += len;
      end
    end
    drain_ct();
    chk("rnd_level", c_lvl, 0);
    chk("rnd_bursts", c_bc, 0);

    // Reset in the middle of a burst
    c_mready = 1'b0;
    ct_beat(32'h6000_0000, 4'hF, 1'b1, 1'b0);
    ct_beat(32'h6000_0001, 4'hF, 1'b0, 1'b0);
    ct_beat(32'h6000_0002, 4'hF, 1'b0, 1'b0);
    chk("pre_rst_state", {c_mvalid, c_lvl, c_bc}, {1'b1, 10'd2, 10'd1});
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", c_mvalid, 0);
    chk("mid_rst_level", c_lvl, 0);
    chk("mid_rst_bursts", c_bc, 0);
    chk("mid_rst_data", c_mdata, 0);
    chk("mid_rst_s_wready", c_swready, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_s_wready", c_swready, 1);
    c_mready = 1'b1;
    ct_beat(32'h7000_0001, 4'h3, 1'b0, 1'b0);
    ct_beat(32'h7000_0002, 4'hC, 1'b1, 1'b0);
    drain_ct();
    chk("post_rst_level", c_lvl, 0);
    chk("post_rst_bursts", c_bc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
